// File: rtl/postage_maxi_hls_deadlock_reporter.sv
// Qualifies per-monitor HLS block signals by persistence, latching the first deadlock as a sticky report plus one-cycle irq.
// Report visible one edge after a counter reaches threshold; no backpressure, inputs sampled every cycle.
module postage_maxi_hls_deadlock_reporter #(
  parameter  int NUM_MON  = 4,
  parameter  int THRESH_W = 16,
  parameter  int TS_W     = 32,
  localparam int IDX_W    = (NUM_MON > 1) ? $clog2(NUM_MON) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                clear,
  input  logic [THRESH_W-1:0] thresh,
  input  logic [NUM_MON-1:0]  mon_block,
  output logic                any_block,
  output logic                deadlock,
  output logic [IDX_W-1:0]    deadlock_idx,
  output logic [NUM_MON-1:0]  deadlock_mask,
  output logic [TS_W-1:0]     deadlock_time,
  output logic                irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ARMED   = 2'd1,
    S_LATCHED = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [THRESH_W-1:0] cnt [NUM_MON];
  logic [THRESH_W-1:0] thresh_eff;
  logic [NUM_MON-1:0]  qual;
  logic [IDX_W-1:0]    low_idx;
  logic                latch_fire;
  logic [TS_W-1:0]     ts;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) ts <= '0;
    else       ts <= ts + TS_W'(1);
  end

  // Counters saturate rather than wrap so a very long stall never looks freshly started.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MON; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MON; i++) begin
        if (clear || !enable || !mon_block[i]) cnt[i] <= '0;
        else if (cnt[i] != '1)                 cnt[i] <= cnt[i] + THRESH_W'(1);
      end
    end
  end

  assign thresh_eff = (thresh == '0) ? THRESH_W'(1) : thresh;

  always_comb begin
    qual = '0;
    for (int i = 0; i < NUM_MON; i++) qual[i] = enable && (cnt[i] >= thresh_eff);
  end

  always_comb begin
    low_idx = '0;
    for (int i = NUM_MON - 1; i >= 0; i--) begin
      if (qual[i]) low_idx = IDX_W'(i);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (enable) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (clear)        state_nxt = enable ? S_ARMED : S_IDLE;
        else if (|qual)   state_nxt = S_LATCHED;
        else if (!enable) state_nxt = S_IDLE;
      end
      S_LATCHED: begin
        if (clear) state_nxt = enable ? S_ARMED : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Clear wins over a same-edge qualification.
  always_comb begin
    latch_fire = (state == S_ARMED) && (|qual) && !clear;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      any_block     <= 1'b0;
      deadlock      <= 1'b0;
      deadlock_idx  <= '0;
      deadlock_mask <= '0;
      deadlock_time <= '0;
      irq           <= 1'b0;
    end else begin
      any_block <= |mon_block;
      irq       <= latch_fire;
      if (clear) begin
        deadlock      <= 1'b0;
        deadlock_idx  <= '0;
        deadlock_mask <= '0;
        deadlock_time <= '0;
      end else if (latch_fire) begin
        deadlock      <= 1'b1;
        deadlock_idx  <= low_idx;
        deadlock_mask <= qual;
        deadlock_time <= ts;
      end
    end
  end

endmodule

// File: tb/tb_postage_maxi_hls_deadlock_reporter.sv
// Directed bench for the deadlock reporter; an 8-bit timestamp keeps the wrap reachable.
module tb_postage_maxi_hls_deadlock_reporter;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        clear;
  logic [15:0] thresh;
  logic [3:0]  mon_block;
  logic        any_block;
  logic        deadlock;
  logic [1:0]  deadlock_idx;
  logic [3:0]  deadlock_mask;
  logic [7:0]  deadlock_time;
  logic        irq;

  int tests = 0;
  int fails = 0;
  logic [7:0] tb_ts;

  postage_maxi_hls_deadlock_reporter #(
    .NUM_MON (4),
    .THRESH_W(16),
    .TS_W    (8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .clear        (clear),
    .thresh       (thresh),
    .mon_block    (mon_block),
    .any_block    (any_block),
    .deadlock     (deadlock),
    .deadlock_idx (deadlock_idx),
    .deadlock_mask(deadlock_mask),
    .deadlock_time(deadlock_time),
    .irq          (irq)
  );

  always #5 clock = ~clock;

  // Reference timestamp: counts edges since reset.
  always @(posedge clock or posedge reset) begin
    if (reset) tb_ts <= 8'd0;
    else       tb_ts <= tb_ts + 8'd1;
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; clear = 1'b0; thresh = 16'd3; mon_block = 4'b0000;
    #12;
    tests++;
    if ({any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time} !== 17'd0) begin
      fails++;
      $display("FAIL reset_values got=%h want=0", {any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time});
    end
    #10 reset = 1'b0;
    tick;
    enable = 1'b1;
    tick;
    tests++;
    if ({deadlock, irq} !== 2'b00) begin
      fails++; $display("FAIL armed_idle got=%b want=00", {deadlock, irq});
    end
  endtask

  task automatic test_basic_latch;
    mon_block = 4'b0100; thresh = 16'd3;
    repeat (3) tick;
    tests++;
    if ({deadlock, irq} !== 2'b00) begin
      fails++; $display("FAIL basic_early got=%b want=00", {deadlock, irq});
    end
    tick;
    tests++;
    if ({deadlock, irq, deadlock_idx, deadlock_mask} !== {1'b1, 1'b1, 2'd2, 4'b0100}) begin
      fails++; $display("FAIL basic_report got=%b want=11100100", {deadlock, irq, deadlock_idx, deadlock_mask});
    end
    tests++;
    if (deadlock_time !== 8'd5) begin
      fails++; $display("FAIL basic_time got=%0d want=5", deadlock_time);
    end
    tick;
    tests++;
    if ({deadlock, irq} !== 2'b10) begin
      fails++; $display("FAIL basic_irq_once got=%b want=10", {deadlock, irq});
    end
  endtask

  task automatic test_glitch_restart;
    logic [3:0] pat [6];
    pat = '{4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000};
    clear = 1'b1; mon_block = 4'b0000; thresh = 16'd3;
    tick;
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mon_block = pat[i];
      tick;
      tests++;
      if ({any_block, deadlock, irq} !== {|pat[i], 2'b00}) begin
        fails++;
        $display("FAIL glitch_step%0d got=%b want=%b", i, {any_block, deadlock, irq}, {|pat[i], 2'b00});
      end
    end
  endtask

  task automatic test_simultaneous;
    logic irq_seen;
    clear = 1'b1;
    tick;
    clear = 1'b0; thresh = 16'd5; mon_block = 4'b1010;
    repeat (5) tick;
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL simul_early got=%b want=0", deadlock);
    end
    tick;
    tests++;
    if ({deadlock, irq, deadlock_idx, deadlock_mask} !== {1'b1, 1'b1, 2'd1, 4'b1010}) begin
      fails++; $display("FAIL simul_report got=%b want=11011010", {deadlock, irq, deadlock_idx, deadlock_mask});
    end
    mon_block = 4'b1011;
    irq_seen = 1'b0;
    repeat (8) begin
      tick;
      if (irq) irq_seen = 1'b1;
    end
    tests++;
    if ({irq_seen, deadlock, deadlock_idx, deadlock_mask} !== {1'b0, 1'b1, 2'd1, 4'b1010}) begin
      fails++; $display("FAIL simul_sticky got=%b want=01011010", {irq_seen, deadlock, deadlock_idx, deadlock_mask});
    end
  endtask

  task automatic test_clear;
    clear = 1'b1; mon_block = 4'b0100; thresh = 16'd3;
    tick;
    clear = 1'b0;
    repeat (4) tick;
    tests++;
    if ({deadlock, irq} !== 2'b11) begin
      fails++; $display("FAIL clear_setup got=%b want=11", {deadlock, irq});
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tests++;
    if ({deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time} !== 16'd0) begin
      fails++;
      $display("FAIL clear_zero got=%h want=0", {deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time});
    end
    repeat (3) tick;
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL clear_requal_early got=%b want=0", deadlock);
    end
    tick;
    tests++;
    if ({deadlock, irq, deadlock_idx} !== {1'b1, 1'b1, 2'd2}) begin
      fails++; $display("FAIL clear_requal got=%b want=1110", {deadlock, irq, deadlock_idx});
    end
    clear = 1'b1;
    tick;
    clear = 1'b0;
    repeat (3) tick;
    clear = 1'b1;
    tick;
    clear = 1'b0;
    tests++;
    if ({deadlock, irq} !== 2'b00) begin
      fails++; $display("FAIL clear_priority got=%b want=00", {deadlock, irq});
    end
    tick;
    tests++;
    if ({deadlock, irq} !== 2'b00) begin
      fails++; $display("FAIL clear_priority_after got=%b want=00", {deadlock, irq});
    end
  endtask

  task automatic test_thresh_zero;
    clear = 1'b1; mon_block = 4'b0000;
    tick;
    clear = 1'b0; thresh = 16'd0; mon_block = 4'b0001;
    tick;
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL thresh0_early got=%b want=0", deadlock);
    end
    mon_block = 4'b0000;
    tick;
    tests++;
    if ({deadlock, irq, deadlock_idx, deadlock_mask} !== {1'b1, 1'b1, 2'd0, 4'b0001}) begin
      fails++; $display("FAIL thresh0_report got=%b want=11000001", {deadlock, irq, deadlock_idx, deadlock_mask});
    end
  endtask

  task automatic test_enable_gate;
    logic seen;
    clear = 1'b1; enable = 1'b0; thresh = 16'd2; mon_block = 4'b0001;
    tick;
    clear = 1'b0;
    seen = 1'b0;
    repeat (100) begin
      tick;
      if (deadlock || irq) seen = 1'b1;
    end
    tests++;
    if (seen !== 1'b0) begin
      fails++; $display("FAIL enable_off_latch got=%b want=0", seen);
    end
    enable = 1'b1;
    repeat (2) tick;
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL enable_rise_early got=%b want=0", deadlock);
    end
    tick;
    tests++;
    if ({deadlock, irq} !== 2'b11) begin
      fails++; $display("FAIL enable_rise_latch got=%b want=11", {deadlock, irq});
    end
  endtask

  task automatic test_async_reset;
    clear = 1'b1; mon_block = 4'b0100; thresh = 16'd3;
    tick;
    clear = 1'b0;
    repeat (2) tick;
    tests++;
    if (any_block !== 1'b1) begin
      fails++; $display("FAIL midcount_any got=%b want=1", any_block);
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time} !== 17'd0) begin
      fails++;
      $display("FAIL reset_midcount got=%h want=0", {any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time});
    end
    #1 reset = 1'b0;
    repeat (3) tick;
    tests++;
    if (deadlock !== 1'b0) begin
      fails++; $display("FAIL post_reset_early got=%b want=0", deadlock);
    end
    tick;
    tests++;
    if ({deadlock, irq} !== 2'b11) begin
      fails++; $display("FAIL post_reset_latch got=%b want=11", {deadlock, irq});
    end
    #3 reset = 1'b1;
    #1;
    tests++;
    if ({any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time} !== 17'd0) begin
      fails++;
      $display("FAIL reset_latched got=%h want=0", {any_block, deadlock, irq, deadlock_idx, deadlock_mask, deadlock_time});
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_ts_wrap;
    int n;
    clear = 1'b1; mon_block = 4'b0000; thresh = 16'd3;
    n = 0;
    while (tb_ts != 8'd252 && n < 600) begin
      tick;
      n++;
    end
    tests++;
    if (tb_ts !== 8'd252) begin
      fails++; $display("FAIL ts_wait_timeout got=%0d want=252", tb_ts);
    end
    clear = 1'b0; mon_block = 4'b0100;
    repeat (4) tick;
    tests++;
    if ({deadlock, deadlock_time} !== {1'b1, 8'hFF}) begin
      fails++; $display("FAIL ts_wrap_edge got=%b/%h want=1/ff", deadlock, deadlock_time);
    end
    clear = 1'b1; thresh = 16'd0;
    tick;
    clear = 1'b0;
    repeat (2) tick;
    tests++;
    if ({deadlock, deadlock_time} !== {1'b1, 8'h02}) begin
      fails++; $display("FAIL ts_after_wrap got=%b/%h want=1/02", deadlock, deadlock_time);
    end
  endtask

  initial begin
    test_reset;
    test_basic_latch;
    test_glitch_restart;
    test_simultaneous;
    test_clear;
    test_thresh_zero;
    test_enable_gate;
    test_async_reset;
    test_ts_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/postage_maxi_hls_deadlock_reporter.md
Name: postage_maxi_hls_deadlock_reporter

Overview:
Consumer end of the HLS deadlock monitor network. It receives the per-instance `block` outputs of several deadlock monitors and qualifies each as a real deadlock only when it persists for a programmable number of cycles. On the first qualified deadlock it latches a sticky report (which monitor, which set of monitors, when) and raises a one-cycle interrupt. It sits beside the postage_maxi kernel and feeds the debug/status register file.

Parameters:
NUM_MON, 4, number of monitor block inputs (1..32)
THRESH_W, 16, width of persistence threshold and per-monitor stall counters
TS_W, 32, width of free-running timestamp
IDX_W, clog2(NUM_MON) min 1, width of reported index (derived, not overridable)

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = detection armed; 0 = counters forced to 0, no new latch
clear  in  1  single-cycle pulse; clears the latched report and all counters
thresh  in  THRESH_W  persistence threshold in cycles; 0 is treated as 1
mon_block  in  NUM_MON  block outputs of the deadlock monitors, synchronous to clock
any_block  out  1  registered OR of mon_block (raw, unqualified)
deadlock  out  1  sticky: a qualified deadlock has been latched
deadlock_idx  out  IDX_W  lowest qualified monitor index at the latch edge
deadlock_mask  out  NUM_MON  qualified vector at the latch edge
deadlock_time  out  TS_W  timestamp value at the latch edge
irq  out  1  one-cycle pulse on the latch edge

Behaviour:
- Reset (async assert) values: all counters 0, ts 0, state IDLE, any_block 0, deadlock 0, deadlock_idx 0, deadlock_mask 0, deadlock_time 0, irq 0.
- ts: free-running TS_W counter, +1 every cycle, wraps to 0 at all-ones. It ignores enable and clear.
- thresh_eff = (thresh == 0) ? 1 : thresh. It is compared live every cycle, so changing it mid-count takes effect immediately.
- Per-monitor counter cnt[i], updated each edge:
  - 0 if clear, or enable = 0, or mon_block[i] = 0.
  - Otherwise cnt + 1, saturating at all-ones (no wrap).
- qual[i] = enable & (cnt[i] >= thresh_eff). This is combinational.
- any_block <= |mon_block, giving 1-cycle latency.
- States:
  - IDLE: entered when enable = 0. Moves to ARMED when enable = 1 and not LATCHED.
  - ARMED: if |qual, go to LATCHED. If enable = 0, go to IDLE.
  - LATCHED: held regardless of enable or mon_block. Exits only on clear, to ARMED if enable = 1, else IDLE.
- Latch edge (ARMED and |qual, with clear = 0):
  - deadlock <= 1, irq <= 1.
  - deadlock_idx <= lowest i with qual[i].
  - deadlock_mask <= qual.
  - deadlock_time <= ts (pre-increment value).
  - Only the first event is captured. Later qualifications while LATCHED do not alter the report and raise no irq.
- Latency: if mon_block[i] is sampled high for the first time at edge 1 and stays high, cnt reaches T = thresh_eff at edge T, and deadlock/irq become visible after edge T+1.
- irq is 1 for exactly one cycle per latch and is 0 in every other cycle.
- clear:
  - Has priority over a same-cycle latch: no latch and no irq that edge.
  - Zeroes deadlock, deadlock_idx, deadlock_mask, deadlock_time and all counters.
  - A still-asserted block re-qualifies only after a full thresh_eff again.
- mon_block deasserting for a single cycle restarts that monitor's count from 0.
- Simultaneous qualification of several monitors: mask reports all of them, idx reports the lowest.
- Reset mid-count or while LATCHED: every output returns to its reset value immediately (async).
- Release of reset is synchronised externally. The block assumes reset deasserts away from clock edges.

Test Plan:
- NUM_MON=4, thresh=3, enable=1; mon_block[2] high continuously from edge 1 → deadlock=1, irq pulses once after edge 4; idx=2, mask=4'b0100, deadlock_time=ts sampled at edge 4.
- thresh=3; mon_block[1] high 2 cycles, low 1, high 2 → no deadlock, no irq; any_block follows input delayed 1 cycle.
- mon_block[3] and mon_block[1] rise on the same edge, thresh=5 → idx=1, mask=4'b1010; mon_block[0] later qualifies → report unchanged, no second irq.
- Latched with mon_block[2] still high, clear pulse → outputs 0 next cycle; deadlock re-asserts exactly thresh_eff+1 cycles after clear. Clear coincident with a qualifying edge → no irq that cycle.
- thresh=0, enable=1, mon_block[0] high one sampled edge → latches after the next edge (treated as 1). With enable=0 for 100 blocked cycles → no latch; enable rise → latch after thresh_eff+1 cycles.
- Assert reset asynchronously mid-count and while LATCHED → all outputs 0 without a clock edge. Run ts to 2^TS_W−1 (force) → wraps to 0; a latch recorded at the wrap edge reports 2^TS_W−1.
